glip_channel_arbiter: RTL and testbench
=======================================

GLIP_CHANNEL_ARBITER -- requirements
Module: glip_channel_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width of every channel and of the GLIP FIFO output.
REQ-002 SHALL have parameter NUM_CH, default 4, number of requester channels, legal range 2..8.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum data words per grant, legal range 1..1024.
REQ-004 SHALL have port clk, input, 1, single clock; all logic is in this domain.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port ch_valid, input, NUM_CH, per-channel word valid.
REQ-007 SHALL have port ch_ready, output, NUM_CH, per-channel word accepted.
REQ-008 SHALL have port ch_data, input, NUM_CH*WIDTH, channel i data in bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port ch_last, input, NUM_CH, end of packet, qualified by ch_valid.
REQ-010 SHALL have port fifo_out_valid, output, 1, word valid towards the GLIP FIFO out port.
REQ-011 SHALL have port fifo_out_ready, input, 1, GLIP FIFO out port accepts the word.
REQ-012 SHALL have port fifo_out_data, output, WIDTH, word towards the GLIP FIFO out port.
REQ-013 SHALL have port active_ch, output, 3, index of the granted channel, 0 when idle.
REQ-014 SHALL have port busy, output, 1, high while a grant is held.

Function
REQ-015 SHALL implement states IDLE, HEADER and BURST; HEADER exists only with GLIP_CHAN_HEADER_EN defined.
REQ-016 SHALL, in IDLE, grant round-robin on any ch_valid: search starts at last granted channel + 1, wraps modulo NUM_CH.
REQ-017 SHALL register the grant on the IDLE cycle it is decided, entering HEADER (macro defined) or BURST (undefined) next cycle; arbitration latency is 1 cycle.
REQ-018 SHALL, in BURST, drive fifo_out_valid = ch_valid[g], fifo_out_data = ch_data[g] and ch_ready[g] = fifo_out_ready combinationally, with g the granted channel.
REQ-019 SHALL keep ch_ready low for every non-granted channel and for all channels in IDLE and HEADER.
REQ-020 SHALL count accepted BURST words (valid & ready) in a counter of width $clog2(MAX_BURST+1), cleared on grant.
REQ-021 SHALL leave BURST for IDLE after the transfer cycle in which ch_last[g] is accepted or the counter reaches MAX_BURST; if both happen in the same cycle the exit occurs once.
REQ-022 SHALL leave BURST for IDLE on any cycle with ch_valid[g] low and no transfer, so that a stalled requester does not block others.
REQ-023 SHALL NOT end a burst while fifo_out_ready is low and ch_valid[g] is high; the word is held (back-pressure).
REQ-024 SHALL update the round-robin pointer to g when leaving BURST, never in IDLE.
REQ-025 SHALL drive busy high in HEADER and BURST and active_ch = g there.

Reset
REQ-026 SHALL, on rst sampled high, enter IDLE and clear the counter; the round-robin pointer SHALL be set so that channel 0 has top priority.
REQ-027 SHALL, after reset, hold fifo_out_valid = 0, ch_ready = 0, busy = 0, active_ch = 0 and fifo_out_data = 0.
REQ-028 SHALL abandon a burst or header on reset mid-operation without completing it; no partial word is emitted after the reset cycle.

Configuration
REQ-029 SHALL, with GLIP_CHAN_HEADER_EN defined, emit one header word in HEADER before each burst: bits [WIDTH-1:WIDTH-2] = 2'b11, bits [2:0] = g, other bits 0; fifo_out_valid high, held until fifo_out_ready, then BURST.
REQ-030 SHALL, without GLIP_CHAN_HEADER_EN, contain no HEADER state, and grants go IDLE -> BURST directly.

Structure
REQ-031 SHALL place the state encoding (IDLE, HEADER, BURST) and the header marker constant 2'b11 in the shared package glip_pkg.
REQ-032 SHALL use one sub-module, glip_rr_arbiter: a combinational round-robin picker with request and pointer inputs and one-hot grant and index outputs.

Verification
REQ-033 SHALL cover: only ch1 valid, 3 words, last on word 3, ready always high -> ch1 granted 1 cycle later, words appear in order, then IDLE, active_ch = 1 while busy.
REQ-034 SHALL cover: all 4 channels continuously valid, MAX_BURST = 4, no last -> grant order 0,1,2,3,0, each burst exactly 4 words.
REQ-035 SHALL cover: ch2 granted, fifo_out_ready low for 5 cycles mid-burst -> word held stable, ch_ready[2] low, no grant change, burst resumes.
REQ-036 SHALL cover: ch0 granted, ch_valid[0] drops after 2 words while ch3 waits -> exit to IDLE, ch3 granted next.
REQ-037 SHALL cover: rst asserted for 1 cycle during BURST -> next cycle all outputs 0, IDLE; with ch0 and ch2 valid, ch0 is granted first.
REQ-038 SHALL cover, with GLIP_CHAN_HEADER_EN and WIDTH 16: ch3 granted -> header 16'hC003 precedes its data words; header held under back-pressure.

Source files
------------

// File: rtl/glip_pkg.sv
// ============================================================================
// Module : glip_pkg
// Brief  : Shared FSM encoding and header marker for the GLIP channel arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package glip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_BURST  = 2'd2
    } state_t;

    // Top two bits of a channel header word
    localparam logic [1:0] c_HDR_MARKER = 2'b11;

endpackage

`default_nettype wire

// File: rtl/glip_rr_arbiter.sv
// ============================================================================
// Module : glip_rr_arbiter
// Brief  : Combinational round-robin picker; search starts at i_ptr + 1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module glip_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IW     = 2
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IW-1:0]     i_ptr,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [IW-1:0]     o_idx,
    output logic              o_any
);

    int w_dist;
    int w_best_d;
    int w_best_i;

    // Pick the requester with the smallest circular distance past the pointer
    always_comb begin
        w_dist   = 0;
        w_best_d = NUM_CH;
        w_best_i = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_dist = (i + NUM_CH - 1 - int'(i_ptr)) % NUM_CH;
            if (i_req[i] && (w_dist < w_best_d)) begin
                w_best_d = w_dist;
                w_best_i = i;
            end
        end
    end

    assign o_any = |i_req;
    assign o_idx = IW'(w_best_i);

    always_comb begin
        o_gnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            o_gnt[i] = o_any && (w_best_i == i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/glip_channel_arbiter.sv
// ============================================================================
// Module : glip_channel_arbiter
// Brief  : Round-robin burst arbiter feeding the GLIP FIFO out port.
//          Optional per-burst header word: define GLIP_CHAN_HEADER_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module glip_channel_arbiter
    import glip_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NUM_CH    = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_valid,
    output logic [NUM_CH-1:0]       ch_ready,
    input  logic [NUM_CH*WIDTH-1:0] ch_data,
    input  logic [NUM_CH-1:0]       ch_last,
    output logic                    fifo_out_valid,
    input  logic                    fifo_out_ready,
    output logic [WIDTH-1:0]        fifo_out_data,
    output logic [2:0]              active_ch,
    output logic                    busy
);

    localparam int             IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int             CW    = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  c_MAX = CW'(MAX_BURST);

    state_t              r_state;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_g;
    logic [NUM_CH-1:0]   r_gnt_oh;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic [2:0]          r_active;

    logic [NUM_CH-1:0]   w_gnt;
    logic [IW-1:0]       w_idx;
    logic                w_any;
    logic                w_valid;
    logic                w_last;
    logic [WIDTH-1:0]    w_data;
    logic                w_xfer;
    logic [CW-1:0]       w_cnt_inc;

    glip_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IW     (IW)
    ) u_rr (
        .i_req  (ch_valid),
        .i_ptr  (r_ptr),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // Granted-channel view, selected by the registered one-hot grant
    always_comb begin
        w_valid = 1'b0;
        w_last  = 1'b0;
        w_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_gnt_oh[i]) begin
                w_valid = ch_valid[i];
                w_last  = ch_last[i];
                w_data  = ch_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer    = (r_state == ST_BURST) && w_valid && fifo_out_ready;
    assign w_cnt_inc = r_cnt + CW'(1);

`ifdef GLIP_CHAN_HEADER_EN
    logic [WIDTH-1:0] w_hdr;

    always_comb begin
        w_hdr                 = '0;
        w_hdr[WIDTH-1 -: 2]   = c_HDR_MARKER;
        w_hdr[2:0]            = r_active;
    end
`endif

    always_comb begin
        fifo_out_valid = 1'b0;
        fifo_out_data  = '0;
        ch_ready       = '0;
        if (r_state == ST_BURST) begin
            fifo_out_valid = w_valid;
            fifo_out_data  = w_data;
            ch_ready       = r_gnt_oh & {NUM_CH{fifo_out_ready}};
        end
`ifdef GLIP_CHAN_HEADER_EN
        else if (r_state == ST_HEADER) begin
            fifo_out_valid = 1'b1;
            fifo_out_data  = w_hdr;
        end
`endif
    end

    assign busy      = r_busy;
    assign active_ch = r_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= IW'(NUM_CH - 1);
            r_g      <= '0;
            r_gnt_oh <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_active <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_g      <= w_idx;
                        r_gnt_oh <= w_gnt;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_active <= 3'(w_idx);
`ifdef GLIP_CHAN_HEADER_EN
                        r_state  <= ST_HEADER;
`else
                        r_state  <= ST_BURST;
`endif
                    end
                end
`ifdef GLIP_CHAN_HEADER_EN
                ST_HEADER: begin
                    if (fifo_out_ready) begin
                        r_state <= ST_BURST;
                    end
                end
`endif
                ST_BURST: begin
                    if (w_xfer) begin
                        r_cnt <= w_cnt_inc;
                    end
                    // A stalled requester (valid low) releases the grant
                    if ((w_xfer && (w_last || (w_cnt_inc == c_MAX))) || !w_valid) begin
                        r_state  <= ST_IDLE;
                        r_ptr    <= r_g;
                        r_gnt_oh <= '0;
                        r_busy   <= 1'b0;
                        r_active <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_glip_channel_arbiter.sv
// ============================================================================
// Module : tb_glip_channel_arbiter
// Brief  : Vector table, directed corner sequences and random traffic against
//          a transaction-level reference model. Honours GLIP_CHAN_HEADER_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_glip_channel_arbiter;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int MB = 4;
`ifdef GLIP_CHAN_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   ch_valid;
    logic [N-1:0]   ch_ready;
    logic [N*W-1:0] ch_data;
    logic [N-1:0]   ch_last;
    logic           fifo_out_valid;
    logic           fifo_out_ready;
    logic [W-1:0]   fifo_out_data;
    logic [2:0]     active_ch;
    logic           busy;

    glip_channel_arbiter #(
        .WIDTH     (W),
        .NUM_CH    (N),
        .MAX_BURST (MB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ch_valid       (ch_valid),
        .ch_ready       (ch_ready),
        .ch_data        (ch_data),
        .ch_last        (ch_last),
        .fifo_out_valid (fifo_out_valid),
        .fifo_out_ready (fifo_out_ready),
        .fifo_out_data  (fifo_out_data),
        .active_ch      (active_ch),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: -1 = no grant held
    int  m_g;
    int  m_last;
    int  m_cnt;
    bit  m_hdr;

    // Sampled outputs and grant/burst history
    bit          s_valid;
    logic [15:0] s_data;
    logic [3:0]  s_ready;
    bit          s_busy;
    logic [2:0]  s_active;
    bit          prev_busy;
    int          cur_words;
    int          grants[$];
    int          words[$];

    typedef struct {
        bit          r;
        logic [3:0]  v;
        logic [3:0]  l;
        bit          rd;
        logic [15:0] d1;
        bit          ev;
        logic [15:0] ed;
        logic [3:0]  er;
        bit          eb;
        logic [2:0]  ea;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_g    = -1;
        m_last = N - 1;
        m_cnt  = 0;
        m_hdr  = 1'b0;
    endtask

    task automatic step(input bit r, input logic [3:0] v, input logic [3:0] l,
                        input bit rd, input logic [63:0] d);
        bit          e_v;
        logic [15:0] e_d;
        logic [3:0]  e_r;
        bit          done;
        rst            = r;
        ch_valid       = v;
        ch_last        = l;
        fifo_out_ready = rd;
        ch_data        = d;
        @(negedge clk);
        s_valid  = fifo_out_valid;
        s_data   = fifo_out_data;
        s_ready  = ch_ready;
        s_busy   = busy;
        s_active = active_ch;

        e_v = 1'b0; e_d = '0; e_r = '0;
        if (m_g >= 0 && m_hdr) begin
            e_v = 1'b1;
            e_d = 16'hC000 | 16'(m_g);
        end else if (m_g >= 0) begin
            e_v = v[m_g];
            e_d = d[m_g*W +: W];
            e_r = rd ? (4'b0001 << m_g) : 4'b0000;
        end
        check("model_valid",  32'(s_valid),  32'(e_v));
        check("model_data",   32'(s_data),   32'(e_d));
        check("model_ready",  32'(s_ready),  32'(e_r));
        check("model_busy",   32'(s_busy),   32'(m_g >= 0));
        check("model_active", 32'(s_active), (m_g >= 0) ? 32'(m_g) : 32'd0);

        if (s_busy && !prev_busy) grants.push_back(int'(s_active));
        if (s_busy && s_valid && rd && (|s_ready)) cur_words++;
        if (!s_busy && prev_busy) begin
            words.push_back(cur_words);
            cur_words = 0;
        end
        prev_busy = s_busy;

        // Advance the model across the coming clock edge
        if (r) begin
            model_reset();
        end else if (m_g < 0) begin
            done = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!done && v[(m_last + k) % N]) begin
                    m_g   = (m_last + k) % N;
                    m_cnt = 0;
                    m_hdr = HDR;
                    done  = 1'b1;
                end
            end
        end else if (m_hdr) begin
            if (rd) m_hdr = 1'b0;
        end else begin
            done = 1'b0;
            if (v[m_g] && rd) begin
                m_cnt++;
                done = l[m_g] || (m_cnt == MB);
            end else if (!v[m_g]) begin
                done = 1'b1;
            end
            if (done) begin
                m_last = m_g;
                m_g    = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hist();
        grants.delete();
        words.delete();
        cur_words = 0;
    endtask

    initial begin
        int exp_order[5];
        logic [63:0] rd_data;
        exp_order = '{0, 1, 2, 3, 0};
        prev_busy = 1'b0;
        cur_words = 0;
        rst = 1'b1; ch_valid = '0; ch_last = '0; fifo_out_ready = 1'b0; ch_data = '0;
        @(posedge clk);
        #1;
        model_reset();

        // rst, valid, last, ready, ch1 data | exp valid, data, ready, busy, active
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 3'd0};
        tbl[1]  = '{1'b0, 4'b0010, 4'b0000, 1'b1, 16'hB001, 1'b0, 16'h0000, 4'b0000, 1'b0, 3'd0};
        tbl[2]  = '{1'b0, 4'b0010, 4'b0000, 1'b1, 16'hB001, 1'b1, 16'hB001, 4'b0010, 1'b1, 3'd1};
        tbl[3]  = '{1'b0, 4'b0010, 4'b0000, 1'b1, 16'hB002, 1'b1, 16'hB002, 4'b0010, 1'b1, 3'd1};
        tbl[4]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 16'hB003, 1'b1, 16'hB003, 4'b0010, 1'b1, 3'd1};
        tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 3'd0};
        tbl[6]  = '{1'b0, 4'b0101, 4'b0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 3'd0};
        tbl[7]  = '{1'b0, 4'b0101, 4'b0000, 1'b1, 16'h0000, 1'b1, 16'h2222, 4'b0100, 1'b1, 3'd2};
        tbl[8]  = '{1'b1, 4'b0101, 4'b0000, 1'b0, 16'h0000, 1'b1, 16'h2222, 4'b0000, 1'b1, 3'd2};
        tbl[9]  = '{1'b0, 4'b0101, 4'b0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 3'd0};
        tbl[10] = '{1'b0, 4'b0101, 4'b0000, 1'b1, 16'h0000, 1'b1, 16'h0A0A, 4'b0001, 1'b1, 3'd0};
        tbl[11] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 16'h0000, 1'b1, 16'h0A0A, 4'b0001, 1'b1, 3'd0};
        tbl[12] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 3'd0};

`ifndef GLIP_CHAN_HEADER_EN
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].rd,
                 {16'h3333, 16'h2222, tbl[i].d1, 16'h0A0A});
            check($sformatf("tbl%0d_valid", i),  32'(s_valid),  32'(tbl[i].ev));
            check($sformatf("tbl%0d_data", i),   32'(s_data),   32'(tbl[i].ed));
            check($sformatf("tbl%0d_ready", i),  32'(s_ready),  32'(tbl[i].er));
            check($sformatf("tbl%0d_busy", i),   32'(s_busy),   32'(tbl[i].eb));
            check($sformatf("tbl%0d_active", i), 32'(s_active), 32'(tbl[i].ea));
        end
`endif

        // All channels valid, no last: rotation 0,1,2,3,0 with full bursts
        step(1'b1, 4'b0000, 4'b0000, 1'b1, 64'h0);
        clear_hist();
        for (int c = 0; c < (HDR ? 32 : 26); c++) begin
            step(1'b0, 4'b1111, 4'b0000, 1'b1, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
        end
        step(1'b0, 4'b0000, 4'b0000, 1'b1, 64'h0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_order%0d", i), (i < grants.size()) ? 32'(grants[i]) : 32'hFFFF, 32'(exp_order[i]));
            check($sformatf("burst_len%0d", i), (i < words.size()) ? 32'(words[i]) : 32'hFFFF, 32'(MB));
        end

        // Back-pressure on ch2 for 5 cycles mid-burst
        step(1'b1, 4'b0000, 4'b0000, 1'b1, 64'h0);
        step(1'b0, 4'b0100, 4'b0000, 1'b1, {16'h0, 16'h5A00, 32'h0});
        if (HDR) step(1'b0, 4'b0100, 4'b0000, 1'b1, {16'h0, 16'h5A00, 32'h0});
        step(1'b0, 4'b0100, 4'b0000, 1'b1, {16'h0, 16'h5A00, 32'h0});
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 4'b0100, 4'b0000, 1'b0, {16'h0, 16'h5A01, 32'h0});
            check("bp_ready",  32'(s_ready),  32'h0);
            check("bp_valid",  32'(s_valid),  32'h1);
            check("bp_data",   32'(s_data),   32'h5A01);
            check("bp_active", 32'(s_active), 32'd2);
        end
        step(1'b0, 4'b0100, 4'b0000, 1'b1, {16'h0, 16'h5A01, 32'h0});
        check("bp_resume", 32'(s_ready), 32'b0100);
        step(1'b0, 4'b0100, 4'b0100, 1'b1, {16'h0, 16'h5A02, 32'h0});
        step(1'b0, 4'b0000, 4'b0000, 1'b1, 64'h0);
        check("bp_done_busy", 32'(s_busy), 32'h0);

        // ch0 stalls after 2 words while ch3 waits
        step(1'b1, 4'b0000, 4'b0000, 1'b1, 64'h0);
        clear_hist();
        step(1'b0, 4'b1001, 4'b0000, 1'b1, {16'h3000, 32'h0, 16'h0C00});
        if (HDR) step(1'b0, 4'b1001, 4'b0000, 1'b1, {16'h3000, 32'h0, 16'h0C00});
        step(1'b0, 4'b1001, 4'b0000, 1'b1, {16'h3000, 32'h0, 16'h0C00});
        step(1'b0, 4'b1001, 4'b0000, 1'b1, {16'h3000, 32'h0, 16'h0C01});
        step(1'b0, 4'b1000, 4'b0000, 1'b1, {16'h3000, 32'h0, 16'h0C02});
        step(1'b0, 4'b1000, 4'b0000, 1'b1, {16'h3000, 32'h0, 16'h0C02});
        check("stall_idle", 32'(s_busy), 32'h0);
        step(1'b0, 4'b1000, 4'b0000, 1'b1, {16'h3000, 32'h0, 16'h0C02});
        check("stall_next_active", 32'(s_active), 32'd3);
        check("stall_order", (grants.size() == 2) ? 32'(grants[0] * 10 + grants[1]) : 32'hFFFF, 32'd3);
        step(1'b0, 4'b0000, 4'b0000, 1'b1, 64'h0);

`ifdef GLIP_CHAN_HEADER_EN
        // ch3 header under back-pressure, then its data word
        step(1'b1, 4'b0000, 4'b0000, 1'b1, 64'h0);
        step(1'b0, 4'b1000, 4'b0000, 1'b0, {16'h7777, 48'h0});
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 4'b1000, 4'b0000, (c == 2), {16'h7777, 48'h0});
            check("hdr_word",  32'(s_data),  32'hC003);
            check("hdr_valid", 32'(s_valid), 32'h1);
            check("hdr_ready", 32'(s_ready), 32'h0);
        end
        step(1'b0, 4'b1000, 4'b1000, 1'b1, {16'h7777, 48'h0});
        check("hdr_data_after", 32'(s_data), 32'h7777);
        step(1'b0, 4'b0000, 4'b0000, 1'b1, 64'h0);
`endif

        // Random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            rd_data = {$urandom, $urandom};
            step(($urandom_range(0, 99) == 0),
                 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 rd_data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
